// File: rtl/bcd_sub_seq_if.sv
// Handshake bundle for the digit-serial BCD subtractor: operand request
// (a, b) in, signed-magnitude result (diff, sign, err) out.
interface bcd_sub_seq_if #(
    parameter int NDIG = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] a;
    logic [4*NDIG-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [4*NDIG-1:0] diff;
    logic              sign;
    logic              err;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, sign, err
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, sign, err
    );
endinterface

// File: rtl/bcd_sub_seq.sv
// Digit-serial BCD subtractor: nine's-complement add pass (LSD first), then an
// end-around-carry or re-complement fix-up pass yielding signed-magnitude A - B.
module bcd_sub_seq #(
    parameter int NDIG = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    bcd_sub_seq_if.slave    bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

    state_t                 state_q, state_d;
    logic [NDIG-1:0][3:0]   a_q, a_d;
    logic [NDIG-1:0][3:0]   b_q, b_d;
    logic [NDIG-1:0][3:0]   s_q, s_d;
    logic [NDIG-1:0][3:0]   diff_q, diff_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   carry_q, carry_d;
    logic                   pos_q, pos_d;
    logic                   fc_q, fc_d;
    logic                   zero_q, zero_d;
    logic                   sign_q, sign_d;
    logic                   err_q, err_d;

    logic                   in_bad;
    logic [3:0]             nine_b;
    logic [4:0]             t;
    logic [4:0]             t_adj;
    logic [4:0]             fix_sum;
    logic [3:0]             fix_dig;
    logic                   fix_carry;
    logic                   last;
    logic                   in_ready;
    logic                   out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            pos_q   <= 1'b0;
            fc_q    <= 1'b0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            diff_q  <= diff_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            pos_q   <= pos_d;
            fc_q    <= fc_d;
            zero_q  <= zero_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        pos_d   = pos_q;
        fc_d    = fc_q;
        zero_d  = zero_q;
        sign_d  = sign_q;
        err_d   = err_q;

        in_bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.a[4*i +: 4] > 4'd9 || bus.b[4*i +: 4] > 4'd9) begin
                in_bad = 1'b1;
            end
        end

        // Add-pass digit: nine's complement of b wraps mod 16 for bad digits.
        nine_b = 4'd9 - b_q[idx_q];
        t      = {1'b0, a_q[idx_q]} + {1'b0, nine_b} + {4'b0, carry_q};
        t_adj  = t + 5'd6;

        fix_sum   = {1'b0, s_q[idx_q]} + {4'b0, fc_q};
        fix_carry = pos_q && (fix_sum == 5'd10);
        if (pos_q) begin
            fix_dig = fix_carry ? 4'd0 : fix_sum[3:0];
        end else begin
            fix_dig = 4'd9 - s_q[idx_q];
        end

        last = (idx_q == LAST);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    err_d   = in_bad;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = ADD;
                end
            end
            ADD: begin
                if (t > 5'd9) begin
                    s_d[idx_q] = t_adj[3:0];
                    carry_d    = 1'b1;
                end else begin
                    s_d[idx_q] = t[3:0];
                    carry_d    = 1'b0;
                end
                if (last) begin
                    pos_d   = carry_d;
                    fc_d    = 1'b1;
                    zero_d  = 1'b1;
                    idx_d   = '0;
                    state_d = FIX;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            FIX: begin
                // Fixed digits overwrite S in place; the final carry is discarded.
                s_d[idx_q] = fix_dig;
                fc_d       = fix_carry;
                zero_d     = zero_q && (fix_dig == 4'd0);
                if (last) begin
                    diff_d  = s_d;
                    sign_d  = ~pos_q & ~zero_d;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.diff      = diff_q;
    assign bus.sign      = sign_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_bcd_sub_seq.sv
// Bench for bcd_sub_seq: directed cases with literal results plus random
// operands, all scored against an integer-arithmetic model of A - B.
module tb_bcd_sub_seq;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] diff;
        logic         sign;
        logic         err;
        int           acc_edge;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;
    bit   first_seen;
    exp_t exp_q[$];
    exp_t new_exp;
    exp_t cur_exp;
    logic [W-1:0] last_diff;
    logic         last_sign;
    logic         last_err;

    bcd_sub_seq_if #(.NDIG(N)) bus ();

    bcd_sub_seq #(.NDIG(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic int bcdToInt(input logic [W-1:0] v);
        int r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] intToBcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int   d;
        e.err = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (av[4*i +: 4] > 4'd9 || bv[4*i +: 4] > 4'd9) e.err = 1'b1;
        end
        d        = bcdToInt(av) - bcdToInt(bv);
        e.sign   = (d < 0);
        e.diff   = intToBcd((d < 0) ? -d : d);
        e.acc_edge = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] randOperand(input bit allow_bad);
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) begin
            if (allow_bad && $urandom_range(0, 5) == 0) r[4*i +: 4] = 4'($urandom_range(10, 15));
            else r[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return r;
    endfunction

    // Scoreboard: an accept seen at this negedge takes effect on the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            first_seen = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                new_exp = model(bus.a, bus.b);
                new_exp.acc_edge = cyc + 1;
                exp_q.push_back(new_exp);
            end
            if (bus.out_valid) begin
                checkOutput("mon_in_ready_low", W'(bus.in_ready), W'(0));
                if (exp_q.size() == 0) begin
                    checkOutput("mon_result_pending", W'(0), W'(1));
                end else begin
                    cur_exp = exp_q[0];
                    if (!first_seen) begin
                        checkOutput("mon_latency", W'(cyc - cur_exp.acc_edge), W'(2 * N));
                        first_seen = 1'b1;
                    end
                    checkOutput("mon_err", W'(bus.err), W'(cur_exp.err));
                    if (!cur_exp.err) begin
                        checkOutput("mon_diff", bus.diff, cur_exp.diff);
                        checkOutput("mon_sign", W'(bus.sign), W'(cur_exp.sign));
                    end
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        first_seen = 1'b0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input int hold_cycles, input bit poke);
        int n;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checkOutput("accept_timeout", W'(0), W'(1));
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        n = 0;
        while (!bus.out_valid && n < 4 * N + 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid) begin
            checkOutput("result_timeout", W'(0), W'(1));
            return;
        end
        last_diff = bus.diff;
        last_sign = bus.sign;
        last_err  = bus.err;
        for (int k = 0; k < hold_cycles; k++) begin
            if (poke) begin
                bus.in_valid = 1'b1;
                bus.a = 16'h1111;
                bus.b = 16'h2222;
            end
            @(negedge clk);
            checkOutput("hold_valid", W'(bus.out_valid), W'(1));
            checkOutput("hold_diff", bus.diff, last_diff);
            checkOutput("hold_sign", W'(bus.sign), W'(last_sign));
            checkOutput("hold_in_ready", W'(bus.in_ready), W'(0));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("idle_in_ready", W'(bus.in_ready), W'(1));
        checkOutput("idle_out_valid", W'(bus.out_valid), W'(0));
    endtask

    task automatic runDirected(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] exp_diff, input logic exp_sign,
                               input logic exp_err, input int hold_cycles, input bit poke);
        exp_t m;
        applyStimulus(av, bv, hold_cycles, poke);
        checkOutput({name, "_err"}, W'(last_err), W'(exp_err));
        if (!exp_err) begin
            checkOutput({name, "_diff"}, last_diff, exp_diff);
            checkOutput({name, "_sign"}, W'(last_sign), W'(exp_sign));
            m = model(av, bv);
            checkOutput({name, "_model"}, m.diff, exp_diff);
        end
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_in_ready"}, W'(bus.in_ready), W'(1));
        checkOutput({name, "_out_valid"}, W'(bus.out_valid), W'(0));
        checkOutput({name, "_diff"}, bus.diff, W'(0));
        checkOutput({name, "_sign"}, W'(bus.sign), W'(0));
        checkOutput({name, "_err"}, W'(bus.err), W'(0));
    endtask

    initial begin
        int n;
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        first_seen    = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        runDirected("basic",     16'h0753, 16'h0128, 16'h0625, 1'b0, 1'b0, 0, 1'b0);
        runDirected("negative",  16'h0128, 16'h0753, 16'h0625, 1'b1, 1'b0, 0, 1'b0);
        runDirected("zero_minus", 16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 0, 1'b0);
        runDirected("max_minus", 16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 0, 1'b0);
        runDirected("equal",     16'h4321, 16'h4321, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        runDirected("ripple",    16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 0, 1'b0);
        runDirected("backpress", 16'h5555, 16'h1234, 16'h4321, 1'b0, 1'b0, 5, 1'b1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("no_stray_accept", W'(bus.out_valid), W'(0));
        end
        @(posedge clk);
        #1;
        runDirected("bad_digit", 16'h00A3, 16'h0001, 16'h0000, 1'b0, 1'b1, 0, 1'b0);
        runDirected("err_clear", 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

        // Abort an operation in its fix-up pass with an asynchronous reset.
        bus.a = 16'h0753;
        bus.b = 16'h0128;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        runDirected("post_reset", 16'h0010, 16'h0020, 16'h0010, 1'b1, 1'b0, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            applyStimulus(randOperand(i % 4 == 3), randOperand(i % 4 == 3),
                          int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        checkOutput("queue_drained", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
